// File: rtl/mem_pkg.sv
// Shared definitions for the non-blocking memory stage: load-op and exception
// bit positions, the queue entry layout, and the cancel-counter width helper.
package mem_pkg;

  // One-hot load_op encoding {ld.b, ld.bu, ld.h, ld.hu, ld.w}
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // Exception vector {INE, BRK, SYS, ALE, ADEF, INT}
  localparam int EXC_INE  = 5;
  localparam int EXC_BRK  = 4;
  localparam int EXC_SYS  = 3;
  localparam int EXC_ALE  = 2;
  localparam int EXC_ADEF = 1;
  localparam int EXC_INT  = 0;
  localparam int EXC_W    = 6;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  load_op;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        res_from_mem;
    logic        need_data;
    logic        got_data;
    logic [31:0] result;
  } mem_entry_t;

  // Wide enough for DEPTH queued requests plus the one EX may have in flight.
  function automatic int CNT_W(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: picks the byte/halfword lane from the
// address low bits and sign- or zero-extends according to the load type.
module mem_load_align (
  input  logic [4:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  import mem_pkg::*;

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = rdata[8*addr_lo +: 8];
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    if (load_op[LD_B])       result = 32'(byte_s);
    else if (load_op[LD_BU]) result = {24'h0, byte_s};
    else if (load_op[LD_H])  result = 32'(half_s);
    else if (load_op[LD_HU]) result = {16'h0, half_s};
    else                     result = rdata;
  end

endmodule

// File: rtl/mem_stage_nb.sv
// MEM stage with an in-order queue of outstanding data requests, load-result
// forwarding to ID, and a discard counter for responses orphaned by a flush.
module mem_stage_nb #(
  parameter int DEPTH = 2,
  parameter int EXC_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [4:0]       in_load_op,
  input  logic [31:0]      in_alu_result,
  input  logic             in_rf_we,
  input  logic [4:0]       in_rf_waddr,
  input  logic             in_res_from_mem,
  input  logic             in_req,
  input  logic [EXC_W-1:0] in_exc,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic             out_rf_we,
  output logic [4:0]       out_rf_waddr,
  output logic [31:0]      out_rf_wdata,
  output logic [EXC_W-1:0] out_exc,
  output logic             exc_pending,
  input  logic [4:0]       q_raddr1,
  input  logic [4:0]       q_raddr2,
  output logic             q_hit1,
  output logic             q_hit2,
  output logic [31:0]      q_data1,
  output logic [31:0]      q_data2,
  output logic             q_stall,
  output logic             cancel_busy
);
  import mem_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QC_W  = $clog2(DEPTH + 1);
  localparam int CW    = CNT_W(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  mem_entry_t       ent_q [DEPTH];
  mem_entry_t       ent_d [DEPTH];
  logic [EXC_W-1:0] exc_q [DEPTH];
  logic [EXC_W-1:0] exc_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [QC_W-1:0]  count_q, count_d;
  logic [CW-1:0]    cancel_q, cancel_d;

  logic             head_done, deq, enq, full;
  logic             tgt_found;
  logic [PTR_W-1:0] tgt_idx;
  logic [CW-1:0]    pend_cnt;
  logic [31:0]      aligned;
  logic [33:0]      fwd1, fwd2;

  // Oldest entry still waiting on the bus receives the next response.
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = head_q;
    pend_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && ent_q[idx].need_data && !ent_q[idx].got_data) begin
        pend_cnt = pend_cnt + CW'(1);
        if (!tgt_found) begin
          tgt_found = 1'b1;
          tgt_idx   = idx;
        end
      end
    end
  end

  mem_load_align u_align (
    .load_op (ent_q[tgt_idx].load_op),
    .addr_lo (ent_q[tgt_idx].alu_result[1:0]),
    .rdata   (rdata),
    .result  (aligned)
  );

  assign head_done   = valid_q[head_q] && (!ent_q[head_q].need_data || ent_q[head_q].got_data);
  assign out_valid   = head_done && !flush;
  assign deq         = out_valid && out_ready;
  assign full        = (count_q == QC_W'(DEPTH));
  assign in_ready    = !full || deq || flush;
  assign enq         = in_valid && in_ready && !flush;
  assign cancel_busy = (cancel_q != '0);

  assign out_pc       = out_valid ? ent_q[head_q].pc     : '0;
  assign out_rf_we    = out_valid && ent_q[head_q].rf_we;
  assign out_rf_waddr = out_valid ? ent_q[head_q].waddr  : '0;
  assign out_rf_wdata = out_valid ? ent_q[head_q].result : '0;
  assign out_exc      = out_valid ? exc_q[head_q]        : '0;

  always_comb begin
    exc_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && exc_q[i] != '0) exc_pending = 1'b1;
  end

  // Returns {hit, stall, data}; the youngest matching writer decides.
  function automatic logic [33:0] fwd_lookup(input logic [4:0] raddr);
    logic [33:0]      r;
    logic             found;
    logic [PTR_W-1:0] idx;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_q - PTR_W'(i + 1);
      if (!found && raddr != 5'd0 && valid_q[idx] && ent_q[idx].rf_we &&
          ent_q[idx].waddr == raddr) begin
        found = 1'b1;
        if (!ent_q[idx].need_data || ent_q[idx].got_data) r = {2'b10, ent_q[idx].result};
        else                                                r = {2'b01, 32'h0};
      end
    end
    return r;
  endfunction

  assign fwd1    = fwd_lookup(q_raddr1);
  assign fwd2    = fwd_lookup(q_raddr2);
  assign q_hit1  = fwd1[33];
  assign q_hit2  = fwd2[33];
  assign q_data1 = fwd1[31:0];
  assign q_data2 = fwd2[31:0];
  assign q_stall = fwd1[32] || fwd2[32];

  always_comb begin
    valid_d  = valid_q;
    ent_d    = ent_q;
    exc_d    = exc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cancel_d = cancel_q;
    if (flush) begin
      valid_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      // Every request still owed a response becomes a discard, including EX's.
      cancel_d = cancel_q + pend_cnt + CW'(in_valid && in_req) - CW'(data_ok);
    end else begin
      if (data_ok) begin
        if (cancel_q != '0) begin
          cancel_d = cancel_q - CW'(1);
        end else if (tgt_found) begin
          ent_d[tgt_idx].got_data = 1'b1;
          if (ent_q[tgt_idx].res_from_mem) ent_d[tgt_idx].result = aligned;
        end
      end
      if (deq) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      // Enqueue after dequeue so a full queue can recycle the head slot.
      if (enq) begin
        valid_d[tail_q] = 1'b1;
        ent_d[tail_q]   = '{pc: in_pc, load_op: in_load_op, alu_result: in_alu_result,
                            rf_we: in_rf_we && (in_exc == '0), waddr: in_rf_waddr,
                            res_from_mem: in_res_from_mem, need_data: in_req,
                            got_data: 1'b0, result: in_alu_result};
        exc_d[tail_q]   = in_exc;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + QC_W'(enq) - QC_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cancel_q <= '0;
    end else begin
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cancel_q <= cancel_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    exc_q <= exc_d;
  end

endmodule

// File: tb/tb_mem_stage_nb.sv
// Directed bench for mem_stage_nb (DEPTH=2): load ordering, alignment,
// back-pressure, flush discards, forwarding and exception gating.
module tb_mem_stage_nb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_alu_result;
  logic [4:0]  in_load_op, in_rf_waddr;
  logic        in_rf_we, in_res_from_mem, in_req;
  logic [5:0]  in_exc;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rf_wdata;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [5:0]  out_exc;
  logic        exc_pending;
  logic [4:0]  q_raddr1, q_raddr2;
  logic        q_hit1, q_hit2, q_stall, cancel_busy;
  logic [31:0] q_data1, q_data2;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_BU = 5'b01000;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b00010;
  localparam logic [4:0] OP_W  = 5'b00001;

  mem_stage_nb #(.DEPTH(2), .EXC_W(6)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_load_op(in_load_op),
    .in_alu_result(in_alu_result), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_res_from_mem(in_res_from_mem), .in_req(in_req), .in_exc(in_exc),
    .data_ok(data_ok), .rdata(rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rf_we(out_rf_we),
    .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata), .out_exc(out_exc),
    .exc_pending(exc_pending), .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2),
    .q_stall(q_stall), .cancel_busy(cancel_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_pc = '0; in_load_op = '0; in_alu_result = '0;
    in_rf_we = 1'b0; in_rf_waddr = '0; in_res_from_mem = 1'b0; in_req = 1'b0;
    in_exc = '0; data_ok = 1'b0; rdata = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] alu,
                       input logic we, input logic [4:0] wa, input logic fm,
                       input logic req, input logic [5:0] exc);
    in_valid = 1'b1; in_pc = pc; in_load_op = op; in_alu_result = alu;
    in_rf_we = we; in_rf_waddr = wa; in_res_from_mem = fm; in_req = req; in_exc = exc;
  endtask

  // Single load, one-cycle response, retired with out_ready high.
  task automatic load_one(input string tag, input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp);
    issue(32'h0000_7000, op, addr, 1'b1, 5'd6, 1'b1, 1'b1, 6'h0);
    tick();
    idle();
    data_ok = 1'b1; rdata = data;
    settle();
    check({tag, "_wait"}, out_valid, 1'b0);
    tick();
    idle();
    settle();
    check({tag, "_vld"}, out_valid, 1'b1);
    check({tag, "_data"}, out_rf_wdata, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1; out_ready = 1'b0; q_raddr1 = '0; q_raddr2 = '0;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_q_stall", q_stall, 1'b0);
    check("rst_q_hit1", q_hit1, 1'b0);
    check("rst_exc_pending", exc_pending, 1'b0);
    check("rst_cancel_busy", cancel_busy, 1'b0);
    check("rst_wdata", out_rf_wdata, 32'h0);
    check("rst_pc", out_pc, 32'h0);

    // Two back-to-back ld.w, responses two and three cycles after the first issue
    out_ready = 1'b1;
    issue(32'h1000, OP_W, 32'h100, 1'b1, 5'd3, 1'b1, 1'b1, 6'h0);
    tick();
    issue(32'h1004, OP_W, 32'h104, 1'b1, 5'd4, 1'b1, 1'b1, 6'h0);
    settle();
    check("ldw_pend0", out_valid, 1'b0);
    tick();
    idle(); data_ok = 1'b1; rdata = 32'hAABBCCDD;
    settle();
    check("ldw_pend1", out_valid, 1'b0);
    tick();
    idle(); data_ok = 1'b1; rdata = 32'h11223344;
    settle();
    check("ldw1_vld", out_valid, 1'b1);
    check("ldw1_pc", out_pc, 32'h1000);
    check("ldw1_data", out_rf_wdata, 32'hAABBCCDD);
    tick();
    idle();
    settle();
    check("ldw2_vld", out_valid, 1'b1);
    check("ldw2_pc", out_pc, 32'h1004);
    check("ldw2_data", out_rf_wdata, 32'h11223344);
    tick();
    settle();
    check("ldw_empty", out_valid, 1'b0);

    // Alignment
    load_one("ldb", OP_B, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
    load_one("ldhu", OP_HU, 32'h102, 32'h80FF0000, 32'h000080FF);
    load_one("ldh", OP_H, 32'h101, 32'h7F008001, 32'hFFFF8001);
    load_one("ldbu", OP_BU, 32'h101, 32'h0000F100, 32'h000000F1);

    // Back-pressure with DEPTH=2
    out_ready = 1'b0;
    issue(32'h2000, 5'h0, 32'h11, 1'b1, 5'd7, 1'b0, 1'b0, 6'h0);
    settle();
    check("bp_rdy0", in_ready, 1'b1);
    tick();
    issue(32'h2004, 5'h0, 32'h22, 1'b1, 5'd8, 1'b0, 1'b0, 6'h0);
    settle();
    check("bp_rdy1", in_ready, 1'b1);
    check("bp_alu_lat", out_valid, 1'b1);
    tick();
    issue(32'h2008, 5'h0, 32'h33, 1'b1, 5'd9, 1'b0, 1'b0, 6'h0);
    settle();
    check("bp_full", in_ready, 1'b0);
    tick();
    out_ready = 1'b1;
    settle();
    check("bp_deq_enq_rdy", in_ready, 1'b1);
    check("bp_head_pc", out_pc, 32'h2000);
    tick();
    idle(); out_ready = 1'b0;
    settle();
    check("bp_still_full", in_ready, 1'b0);
    check("bp_head2_pc", out_pc, 32'h2004);
    out_ready = 1'b1;
    tick();
    settle();
    check("bp_head3_pc", out_pc, 32'h2008);
    check("bp_head3_data", out_rf_wdata, 32'h33);
    tick();
    settle();
    check("bp_drained", out_valid, 1'b0);

    // Flush with two outstanding loads plus one in EX
    issue(32'h3000, OP_W, 32'h200, 1'b1, 5'd9, 1'b1, 1'b1, 6'h0);
    tick();
    issue(32'h3004, OP_W, 32'h204, 1'b1, 5'd10, 1'b1, 1'b1, 6'h0);
    tick();
    issue(32'h3008, OP_W, 32'h208, 1'b1, 5'd11, 1'b1, 1'b1, 6'h0);
    flush = 1'b1;
    settle();
    check("fl_rdy", in_ready, 1'b1);
    check("fl_no_retire", out_valid, 1'b0);
    tick();
    idle();
    settle();
    check("fl_busy", cancel_busy, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      data_ok = 1'b1; rdata = 32'hDEAD0000 + k;
      settle();
      check("fl_drop_vld", out_valid, 1'b0);
      tick();
      data_ok = 1'b0;
      settle();
      check("fl_busy_k", cancel_busy, (k < 3) ? 1'b1 : 1'b0);
    end
    issue(32'h4000, OP_W, 32'h300, 1'b1, 5'd12, 1'b1, 1'b1, 6'h0);
    tick();
    idle(); data_ok = 1'b1; rdata = 32'hCAFEF00D;
    tick();
    idle();
    settle();
    check("fl_new_vld", out_valid, 1'b1);
    check("fl_new_pc", out_pc, 32'h4000);
    check("fl_new_data", out_rf_wdata, 32'hCAFEF00D);
    tick();

    // Forwarding
    out_ready = 1'b0; q_raddr1 = 5'd5; q_raddr2 = 5'd0;
    issue(32'h5000, OP_W, 32'h400, 1'b1, 5'd5, 1'b1, 1'b1, 6'h0);
    tick();
    idle();
    settle();
    check("fw_stall", q_stall, 1'b1);
    check("fw_nohit", q_hit1, 1'b0);
    data_ok = 1'b1; rdata = 32'h12345678;
    tick();
    idle();
    settle();
    check("fw_stall_clr", q_stall, 1'b0);
    check("fw_hit_ld", q_hit1, 1'b1);
    check("fw_data_ld", q_data1, 32'h12345678);
    issue(32'h5004, 5'h0, 32'h0000ABCD, 1'b1, 5'd5, 1'b0, 1'b0, 6'h0);
    tick();
    idle(); q_raddr2 = 5'd5;
    settle();
    check("fw_hit_alu", q_hit1, 1'b1);
    check("fw_data_alu", q_data1, 32'h0000ABCD);
    check("fw_data2_alu", q_data2, 32'h0000ABCD);
    q_raddr2 = 5'd0;
    settle();
    check("fw_r0_nohit", q_hit2, 1'b0);
    out_ready = 1'b1;
    tick(); tick();
    settle();
    check("fw_drained", q_hit1, 1'b0);

    // Exception entry
    out_ready = 1'b0; q_raddr1 = 5'd11;
    issue(32'h6000, 5'h0, 32'h55, 1'b1, 5'd11, 1'b0, 1'b0, 6'h20);
    tick();
    idle();
    settle();
    check("exc_pending", exc_pending, 1'b1);
    check("exc_vld", out_valid, 1'b1);
    check("exc_we", out_rf_we, 1'b0);
    check("exc_vec", out_exc, 32'h20);
    check("exc_nofwd", q_hit1, 1'b0);
    out_ready = 1'b1;
    tick();
    settle();
    check("exc_clear", exc_pending, 1'b0);

    // Reset clears a pending discard count
    issue(32'h8000, OP_W, 32'h500, 1'b1, 5'd13, 1'b1, 1'b1, 6'h0);
    tick();
    idle(); flush = 1'b1;
    tick();
    idle();
    settle();
    check("rst2_busy", cancel_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rst2_cancel", cancel_busy, 1'b0);
    check("rst2_vld", out_valid, 1'b0);
    check("rst2_rdy", in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
